// File: rtl/irq_pkg.sv
// Shared definitions for irq_ctrl: sequencer states, config register map and id sizing.
package irq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        VECTOR,
        SERVICE,
        RESTORE
    } irq_state_e;

    localparam logic [1:0] CFG_MASK = 2'd0;
    localparam logic [1:0] CFG_GIE  = 2'd1;
    localparam logic [1:0] CFG_PEND = 2'd2;
    localparam logic [1:0] CFG_STAT = 2'd3;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_prio_enc #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Walk downward so the lowest active index is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IW'(i);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge-latched requests, fixed priority, push/vector entry and pop return.
// Define IRQ_FLAG_SAVE_EN to shadow z/carry in SAVE and request their reload in RESTORE.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          N_IRQ      = 4,
    parameter int          PC_W       = 10,
    parameter int unsigned VEC_BASE   = 32'h3C0,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_IRQ-1:0] irq,
    input  logic [PC_W-1:0]  pc_cur,
    input  logic             cpu_push,
    input  logic             cpu_pop,
    input  logic             reti,
    input  logic             z,
    input  logic             carry,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [N_IRQ-1:0] cfg_wdata,
    output logic [N_IRQ-1:0] cfg_rdata,
    output logic             stall,
    output logic             irq_push,
    output logic [PC_W-1:0]  ret_addr,
    output logic             irq_pop,
    output logic             pc_load,
    output logic [PC_W-1:0]  vec_addr,
    output logic             in_service,
`ifdef IRQ_FLAG_SAVE_EN
    output logic             flag_restore,
    output logic             z_sh,
    output logic             carry_sh,
`endif
    output logic             spurious_reti
);

    localparam int IW = id_width(N_IRQ);

    irq_state_e       state_q;
    logic [N_IRQ-1:0] irq_q, mask_q, pending_q, pending_d;
    logic             gie_q;
    logic [IW-1:0]    id_q;
    logic [PC_W-1:0]  ret_q, vec_q;
    logic             stall_q, push_q, pop_q, load_q, svc_q, spur_q;

    logic [N_IRQ-1:0] eligible, acc_clr, w1c;
    logic             enc_valid, accept;
    logic [IW-1:0]    enc_idx;
    logic [31:0]      vec_full;

    assign eligible = gie_q ? (pending_q & mask_q) : '0;

    irq_prio_enc #(.N(N_IRQ), .IW(IW)) u_prio (
        .req_i   (eligible),
        .valid_o (enc_valid),
        .idx_o   (enc_idx)
    );

    // A stack op by the control unit this cycle defers entry so the two pushes never collide.
    assign accept   = (state_q == IDLE) && enc_valid && !cpu_push && !cpu_pop;
    assign vec_full = VEC_BASE + VEC_STRIDE * 32'(enc_idx);

    assign acc_clr   = accept ? (N_IRQ'(1) << enc_idx) : '0;
    assign w1c       = (cfg_we && cfg_addr == CFG_PEND) ? cfg_wdata : '0;
    assign pending_d = (pending_q & ~(acc_clr | w1c)) | (irq & ~irq_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q     <= '0;
            mask_q    <= '0;
            gie_q     <= 1'b0;
            pending_q <= '0;
        end else begin
            irq_q     <= irq;
            pending_q <= pending_d;
            if (cfg_we && cfg_addr == CFG_MASK) mask_q <= cfg_wdata;
            if (cfg_we && cfg_addr == CFG_GIE)  gie_q  <= cfg_wdata[0];
        end
    end

`ifdef IRQ_FLAG_SAVE_EN
    logic flag_rst_q, z_sh_q, carry_sh_q;
    assign flag_restore = flag_rst_q;
    assign z_sh         = z_sh_q;
    assign carry_sh     = carry_sh_q;
`else
    logic unused_flags;
    assign unused_flags = z ^ carry;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            id_q    <= '0;
            ret_q   <= '0;
            vec_q   <= '0;
            stall_q <= 1'b0;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            load_q  <= 1'b0;
            svc_q   <= 1'b0;
            spur_q  <= 1'b0;
`ifdef IRQ_FLAG_SAVE_EN
            flag_rst_q <= 1'b0;
            z_sh_q     <= 1'b0;
            carry_sh_q <= 1'b0;
`endif
        end else begin
            push_q <= 1'b0;
            pop_q  <= 1'b0;
            load_q <= 1'b0;
            spur_q <= reti && (state_q != SERVICE);
            case (state_q)
                IDLE: if (accept) begin
                    state_q <= SAVE;
                    id_q    <= enc_idx;
                    ret_q   <= pc_cur;
                    vec_q   <= vec_full[PC_W-1:0];
                    stall_q <= 1'b1;
                    push_q  <= 1'b1;
                end
                SAVE: begin
                    state_q <= VECTOR;
                    load_q  <= 1'b1;
`ifdef IRQ_FLAG_SAVE_EN
                    z_sh_q     <= z;
                    carry_sh_q <= carry;
`endif
                end
                VECTOR: begin
                    state_q <= SERVICE;
                    stall_q <= 1'b0;
                    svc_q   <= 1'b1;
                end
                // gie is deliberately not consulted: the return must always complete.
                SERVICE: if (reti) begin
                    state_q <= RESTORE;
                    stall_q <= 1'b1;
                    pop_q   <= 1'b1;
                    svc_q   <= 1'b0;
`ifdef IRQ_FLAG_SAVE_EN
                    flag_rst_q <= 1'b1;
`endif
                end
                RESTORE: begin
                    state_q <= IDLE;
                    stall_q <= 1'b0;
`ifdef IRQ_FLAG_SAVE_EN
                    flag_rst_q <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall         = stall_q;
    assign irq_push      = push_q;
    assign ret_addr      = ret_q;
    assign irq_pop       = pop_q;
    assign pc_load       = load_q;
    assign vec_addr      = vec_q;
    assign in_service    = svc_q;
    assign spurious_reti = spur_q;

    logic [IW:0] stat;
    assign stat = {svc_q, id_q};

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            CFG_MASK: cfg_rdata    = mask_q;
            CFG_GIE:  cfg_rdata[0] = gie_q;
            CFG_PEND: cfg_rdata    = pending_q;
            default: begin
                for (int i = 0; i < N_IRQ && i <= IW; i++) cfg_rdata[i] = stat[i];
            end
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus a randomized run against a timeline model.
module tb_irq_ctrl;

    localparam int N  = 4;
    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  irq = '0;
    logic [PW-1:0] pc_cur = '0;
    logic          cpu_push = 0, cpu_pop = 0, reti = 0, z = 0, carry = 0, cfg_we = 0;
    logic [1:0]    cfg_addr = '0;
    logic [N-1:0]  cfg_wdata = '0;
    logic [N-1:0]  cfg_rdata;
    logic          stall, irq_push, irq_pop, pc_load, in_service, spurious_reti;
    logic [PW-1:0] ret_addr, vec_addr;
`ifdef IRQ_FLAG_SAVE_EN
    logic          flag_restore, z_sh, carry_sh;
`endif

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.N_IRQ(N), .PC_W(PW), .VEC_BASE(32'h3C0), .VEC_STRIDE(4)) dut (
        .clk(clk), .reset_n(reset_n), .irq(irq), .pc_cur(pc_cur),
        .cpu_push(cpu_push), .cpu_pop(cpu_pop), .reti(reti), .z(z), .carry(carry),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .stall(stall), .irq_push(irq_push), .ret_addr(ret_addr), .irq_pop(irq_pop),
        .pc_load(pc_load), .vec_addr(vec_addr), .in_service(in_service),
`ifdef IRQ_FLAG_SAVE_EN
        .flag_restore(flag_restore), .z_sh(z_sh), .carry_sh(carry_sh),
`endif
        .spurious_reti(spurious_reti)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        irq = '0; pc_cur = '0; cpu_push = 0; cpu_pop = 0; reti = 0;
        z = 0; carry = 0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [N-1:0] d);
        cfg_we = 1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 0;
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 0;
        #3;
        checks++; if ({stall, irq_push, irq_pop, pc_load, in_service, spurious_reti} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 000000", {stall, irq_push, irq_pop, pc_load, in_service, spurious_reti}); end
        checks++; if (ret_addr !== 10'h000 || vec_addr !== 10'h000) begin errors++; $display("FAIL reset_addr: got %h/%h want 000/000", ret_addr, vec_addr); end
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a);
            #1;
            checks++; if (cfg_rdata !== 4'h0) begin errors++; $display("FAIL reset_rdata%0d: got %h want 0", a, cfg_rdata); end
        end
        @(negedge clk) reset_n = 1;
    endtask

    task automatic test_basic();
        do_reset();
        cfg_wr(2'd0, 4'hF); cfg_wr(2'd1, 4'h1);
        pc_cur = 10'h020; irq = 4'b0100;
        tick();
        irq = 4'b0; cfg_addr = 2'd2;
        #1;
        checks++; if (cfg_rdata !== 4'b0100 || stall !== 1'b0) begin errors++; $display("FAIL basic_pend: got %b stall %b want 0100 stall 0", cfg_rdata, stall); end
        tick();
        checks++; if (irq_push !== 1'b1 || stall !== 1'b1 || ret_addr !== 10'h020) begin errors++; $display("FAIL basic_push: got push %b stall %b ret %h want 1 1 020", irq_push, stall, ret_addr); end
        tick();
        checks++; if (pc_load !== 1'b1 || irq_push !== 1'b0 || vec_addr !== 10'h3C8) begin errors++; $display("FAIL basic_vector: got load %b push %b vec %h want 1 0 3c8", pc_load, irq_push, vec_addr); end
        tick();
        cfg_addr = 2'd3;
        #1;
        checks++; if (in_service !== 1'b1 || stall !== 1'b0 || cfg_rdata !== 4'b0110) begin errors++; $display("FAIL basic_service: got svc %b stall %b stat %b want 1 0 0110", in_service, stall, cfg_rdata); end
        tick();
        reti = 1; tick(); reti = 0;
        checks++; if (irq_pop !== 1'b1 || stall !== 1'b1 || in_service !== 1'b0 || spurious_reti !== 1'b0) begin errors++; $display("FAIL basic_restore: got pop %b stall %b svc %b spur %b want 1 1 0 0", irq_pop, stall, in_service, spurious_reti); end
        tick();
        checks++; if (irq_pop !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL basic_idle: got pop %b stall %b want 0 0", irq_pop, stall); end
    endtask

    task automatic test_priority();
        do_reset();
        cfg_wr(2'd0, 4'hF); cfg_wr(2'd1, 4'h1);
        irq = 4'b1010; tick(); irq = 4'b0;
        tick();
        tick();
        cfg_addr = 2'd2;
        #1;
        checks++; if (pc_load !== 1'b1 || vec_addr !== 10'h3C4) begin errors++; $display("FAIL prio_vec: got load %b vec %h want 1 3c4", pc_load, vec_addr); end
        checks++; if (cfg_rdata !== 4'b1000) begin errors++; $display("FAIL prio_pend: got %b want 1000", cfg_rdata); end
        tick();
        reti = 1; tick(); reti = 0;
        tick();
        checks++; if (stall !== 1'b0 || in_service !== 1'b0) begin errors++; $display("FAIL prio_gap: got stall %b svc %b want 0 0", stall, in_service); end
        tick();
        checks++; if (irq_push !== 1'b1) begin errors++; $display("FAIL prio_second_push: got %b want 1", irq_push); end
        tick();
        checks++; if (pc_load !== 1'b1 || vec_addr !== 10'h3CC) begin errors++; $display("FAIL prio_second_vec: got load %b vec %h want 1 3cc", pc_load, vec_addr); end
        tick();
        reti = 1; tick(); reti = 0;
        tick();
    endtask

    task automatic test_stack_conflict();
        do_reset();
        cfg_wr(2'd0, 4'hF); cfg_wr(2'd1, 4'h1);
        irq = 4'b0001; tick();
        irq = 4'b0; cpu_push = 1;
        tick();
        checks++; if (irq_push !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL stack_defer1: got push %b stall %b want 0 0", irq_push, stall); end
        tick();
        cpu_push = 0;
        checks++; if (irq_push !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL stack_defer2: got push %b stall %b want 0 0", irq_push, stall); end
        tick();
        checks++; if (irq_push !== 1'b1) begin errors++; $display("FAIL stack_late_push: got %b want 1", irq_push); end
        tick();
        checks++; if (pc_load !== 1'b1 || vec_addr !== 10'h3C0) begin errors++; $display("FAIL stack_vec: got load %b vec %h want 1 3c0", pc_load, vec_addr); end
        tick();
        reti = 1; tick(); reti = 0;
        tick();
    endtask

    task automatic test_mask_w1c();
        do_reset();
        cfg_wr(2'd1, 4'h1);
        irq = 4'b0001; tick(); irq = 4'b0;
        cfg_addr = 2'd2;
        #1;
        checks++; if (cfg_rdata !== 4'b0001) begin errors++; $display("FAIL mask_pend: got %b want 0001", cfg_rdata); end
        tick();
        checks++; if (stall !== 1'b0 || irq_push !== 1'b0) begin errors++; $display("FAIL mask_nostall: got stall %b push %b want 0 0", stall, irq_push); end
        irq = 4'b0001; cfg_we = 1; cfg_addr = 2'd2; cfg_wdata = 4'b0001;
        tick();
        cfg_we = 0; irq = 4'b0;
        #1;
        checks++; if (cfg_rdata !== 4'b0001) begin errors++; $display("FAIL w1c_set_wins: got %b want 0001", cfg_rdata); end
        cfg_wr(2'd2, 4'b0001);
        #1;
        checks++; if (cfg_rdata !== 4'b0000) begin errors++; $display("FAIL w1c_clear: got %b want 0000", cfg_rdata); end
        cfg_addr = 2'd1;
        #1;
        checks++; if (cfg_rdata !== 4'b0001) begin errors++; $display("FAIL gie_read: got %b want 0001", cfg_rdata); end
    endtask

    task automatic test_spurious();
        do_reset();
        reti = 1; tick(); reti = 0;
        checks++; if (spurious_reti !== 1'b1 || irq_pop !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL spur_pulse: got spur %b pop %b stall %b want 1 0 0", spurious_reti, irq_pop, stall); end
        tick();
        checks++; if (spurious_reti !== 1'b0) begin errors++; $display("FAIL spur_width: got %b want 0", spurious_reti); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cfg_wr(2'd0, 4'hF); cfg_wr(2'd1, 4'h1);
        pc_cur = 10'h155; irq = 4'b0010; tick(); irq = 4'b0;
        tick(); tick();
        checks++; if (pc_load !== 1'b1) begin errors++; $display("FAIL midrst_in_vector: got %b want 1", pc_load); end
        #2 reset_n = 0;
        #1;
        cfg_addr = 2'd3;
        #1;
        checks++; if ({stall, irq_push, irq_pop, pc_load, in_service, spurious_reti} !== 6'b0 || ret_addr !== 10'h0 || vec_addr !== 10'h0) begin errors++; $display("FAIL midrst_outputs: got %b ret %h vec %h want zeros", {stall, irq_push, irq_pop, pc_load, in_service, spurious_reti}, ret_addr, vec_addr); end
        @(negedge clk) reset_n = 1;
        tick();
        checks++; if (stall !== 1'b0 || in_service !== 1'b0 || cfg_rdata !== 4'h0) begin errors++; $display("FAIL midrst_idle: got stall %b svc %b stat %b want 0 0 0000", stall, in_service, cfg_rdata); end
    endtask

`ifdef IRQ_FLAG_SAVE_EN
    task automatic test_flags();
        do_reset();
        cfg_wr(2'd0, 4'hF); cfg_wr(2'd1, 4'h1);
        z = 1; carry = 0; irq = 4'b0001; tick(); irq = 4'b0;
        tick();
        tick();
        z = 0; carry = 1;
        checks++; if (z_sh !== 1'b1 || carry_sh !== 1'b0) begin errors++; $display("FAIL flag_shadow: got z %b c %b want 1 0", z_sh, carry_sh); end
        tick();
        reti = 1; tick(); reti = 0;
        checks++; if (flag_restore !== 1'b1) begin errors++; $display("FAIL flag_restore: got %b want 1", flag_restore); end
        tick();
        checks++; if (flag_restore !== 1'b0) begin errors++; $display("FAIL flag_restore_width: got %b want 0", flag_restore); end
    endtask
`endif

    // Model tracks the cycle a request was accepted and the cycle reti was taken,
    // and derives every expected output from its distance to those two points.
    task automatic test_random(input int ncyc);
        logic [N-1:0]  m_mask = '0, m_pend = '0, m_prev = '0, rise, elig, clr, e_rd;
        logic          m_gie = 0, m_spur = 0, m_zs = 0, m_cs = 0;
        logic [PW-1:0] m_ret = '0, m_vec = '0;
        int            m_id = 0, acc = -100, retc = -1, k = 0;
        bit            active = 0, acc_now, e_push, e_load, e_svc, e_pop;
        do_reset();
        for (int n = 0; n < ncyc; n++) begin
            irq      = irq ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            pc_cur   = 10'($urandom);
            z        = 1'($urandom);
            carry    = 1'($urandom);
            cpu_push = ($urandom % 5) == 0;
            cpu_pop  = ($urandom % 7) == 0;
            reti     = ($urandom % 6) == 0;
            cfg_addr = 2'($urandom);
            cfg_we   = ($urandom % 8) == 0;
            cfg_wdata = 4'($urandom);
            if (cfg_we && cfg_addr == 2'd1 && ($urandom % 4) != 0) cfg_wdata[0] = 1'b1;

            e_push = active && k == acc + 1;
            e_svc  = active && k >= acc + 3 && retc < 0;
            e_pop  = active && retc >= 0 && k == retc + 1;
            rise   = irq & ~m_prev;
            elig   = m_gie ? (m_pend & m_mask) : '0;
            acc_now = !active && elig != 0 && !cpu_push && !cpu_pop;
            clr = '0;
            if (acc_now) begin
                m_id = 0;
                while (!elig[m_id]) m_id++;
                clr[m_id] = 1'b1;
                m_ret = pc_cur;
                m_vec = 10'(32'h3C0 + 4 * m_id);
            end
            if (e_push) begin m_zs = z; m_cs = carry; end
            if (cfg_we && cfg_addr == 2'd2) clr |= cfg_wdata;
            m_spur = reti && !e_svc;
            if (reti && e_svc) retc = k;
            if (e_pop) active = 0;
            m_pend = (m_pend & ~clr) | rise;
            if (cfg_we && cfg_addr == 2'd0) m_mask = cfg_wdata;
            if (cfg_we && cfg_addr == 2'd1) m_gie = cfg_wdata[0];
            m_prev = irq;
            if (acc_now) begin active = 1; acc = k; retc = -1; end
            k++;

            tick();

            e_push = active && k == acc + 1;
            e_load = active && k == acc + 2;
            e_svc  = active && k >= acc + 3 && retc < 0;
            e_pop  = active && retc >= 0 && k == retc + 1;
            case (cfg_addr)
                2'd0:    e_rd = m_mask;
                2'd1:    e_rd = {3'b0, m_gie};
                2'd2:    e_rd = m_pend;
                default: e_rd = {1'b0, e_svc, 2'(m_id)};
            endcase
            checks++; if ({stall, irq_push, pc_load, irq_pop, in_service} !== {e_push | e_load | e_pop, e_push, e_load, e_pop, e_svc}) begin errors++; $display("FAIL rand_ctrl cyc %0d: got %b want %b", n, {stall, irq_push, pc_load, irq_pop, in_service}, {e_push | e_load | e_pop, e_push, e_load, e_pop, e_svc}); end
            checks++; if (spurious_reti !== m_spur) begin errors++; $display("FAIL rand_spur cyc %0d: got %b want %b", n, spurious_reti, m_spur); end
            checks++; if (cfg_rdata !== e_rd) begin errors++; $display("FAIL rand_rdata cyc %0d addr %0d: got %b want %b", n, cfg_addr, cfg_rdata, e_rd); end
            if (e_push) begin
                checks++; if (ret_addr !== m_ret) begin errors++; $display("FAIL rand_ret cyc %0d: got %h want %h", n, ret_addr, m_ret); end
            end
            if (e_load) begin
                checks++; if (vec_addr !== m_vec) begin errors++; $display("FAIL rand_vec cyc %0d: got %h want %h", n, vec_addr, m_vec); end
            end
`ifdef IRQ_FLAG_SAVE_EN
            checks++; if ({flag_restore, z_sh, carry_sh} !== {e_pop, m_zs, m_cs}) begin errors++; $display("FAIL rand_flags cyc %0d: got %b want %b", n, {flag_restore, z_sh, carry_sh}, {e_pop, m_zs, m_cs}); end
`endif
        end
        reti = 0; cfg_we = 0; cpu_push = 0; cpu_pop = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_stack_conflict();
        test_mask_w1c();
        test_spurious();
        test_reset_mid();
`ifdef IRQ_FLAG_SAVE_EN
        test_flags();
`endif
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller/sequencer for the single-cycle CPU.
- Latches edge-triggered requests, picks one by fixed priority and stalls the core.
- Sequences entry: push the return PC onto the subroutine stack, then load the vector PC. On RETI it sequences the stack pop back to the interrupted PC.
- Sits beside the control unit and shares the stack and PC-select path with it.

Parameters:
- N_IRQ, 4, number of request lines (1..8).
- PC_W, 10, program-counter width.
- VEC_BASE, 10'h3C0, address of vector 0.
- VEC_STRIDE, 4, address distance between consecutive vectors.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- irq  in  N_IRQ  request lines, synchronous to clk, rising edge = request.
- pc_cur  in  PC_W  PC of the instruction about to execute.
- cpu_push, cpu_pop  in  1  control unit is using the stack this cycle.
- reti  in  1  decoded return-from-interrupt instruction, one-cycle pulse.
- z, carry  in  1  current ALU flags.
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  2  0=mask, 1=global enable (bit0), 2=pending W1C, 3=read-only status.
- cfg_wdata  in  N_IRQ  write data.
- cfg_rdata  out  N_IRQ  combinational read: mask / {0,gie} / pending / {in_service, id}.
- stall  out  1  freeze PC and register-file writes.
- irq_push  out  1  push ret_addr onto the stack.
- ret_addr  out  PC_W  value to push (registered pc_cur).
- irq_pop  out  1  pop the stack into the PC.
- pc_load  out  1  load vec_addr into the PC.
- vec_addr  out  PC_W  VEC_BASE + id*VEC_STRIDE, truncated to PC_W.
- in_service  out  1  a handler is executing.
- spurious_reti  out  1  one-cycle pulse when reti arrives outside SERVICE.

Behaviour:
- Reset (async, any state): FSM=IDLE; mask, gie, pending, id, ret_addr = 0; every output = 0.
- Pending: pending[i] sets on a rising edge of irq[i], detected against the previous-cycle registered irq. It clears on acceptance or on a W1C write. If a set and a clear hit the same bit in one cycle, the set wins.
- Eligible = pending & mask, gated by gie. Priority: lowest index wins.
- IDLE:
  - If eligible ≠ 0 and cpu_push/cpu_pop are both 0: latch id, capture ret_addr=pc_cur, clear pending[id], go to SAVE.
  - If a stack op is active that cycle, entry is deferred by one cycle.
- SAVE (1 cycle): stall=1, irq_push=1 → VECTOR.
- VECTOR (1 cycle): stall=1, pc_load=1, vec_addr valid → SERVICE.
- SERVICE: in_service=1, stall=0, no nesting (new requests only pend). On reti → RESTORE.
- RESTORE (1 cycle): stall=1, irq_pop=1 → IDLE. Re-arbitration is allowed from the following cycle.
- Latency: a request edge at cycle t is pending at t+1. SAVE at t+2, VECTOR at t+3, first handler instruction at t+4.
- reti in IDLE/SAVE/VECTOR/RESTORE: ignored, spurious_reti pulses for one cycle.
- Writes:
  - A mask or gie write takes effect next cycle and does not abort a sequence already in progress.
  - Clearing gie while in SERVICE still permits the return.
- Reset mid-sequence: no push/pop completes; the stack is not re-synchronised by this block.

Optional Feature:
- IRQ_FLAG_SAVE_EN defined:
  - z/carry are captured into shadow registers in SAVE.
  - Extra outputs flag_restore (1), z_sh (1) and carry_sh (1); flag_restore is asserted in RESTORE for the datapath to reload the flags.
- Undefined: those ports and registers are absent, and the flags are not preserved across a handler.

Decomposition:
- Package irq_pkg: FSM state enum (IDLE, SAVE, VECTOR, SERVICE, RESTORE) and cfg_addr constants (CFG_MASK, CFG_GIE, CFG_PEND, CFG_STAT).
- One sub-module, irq_prio_enc: combinational fixed-priority encoder returning any-valid plus index.

Test Plan:
- Basic entry/return: mask=4'hF, gie=1, pc_cur=10'h020, pulse irq[2] → irq_push with ret_addr=10'h020 at t+2, pc_load with vec_addr=10'h3C8 at t+3. Later reti → irq_pop for 1 cycle, then IDLE.
- Priority: irq[3] and irq[1] rise together → vector 10'h3C4 taken. pending=4'b1000 remains and is serviced after RESTORE.
- Stack conflict: eligible request with cpu_push=1 for 2 cycles → SAVE delayed exactly 2 cycles, no push overlap.
- Masking/W1C: mask=0, irq[0] edge → pending=1, no stall. W1C 4'b0001 in the same cycle as a new irq[0] edge → pending[0] stays 1.
- Spurious and reset: reti in IDLE → spurious_reti for 1 cycle, no pop. Assert reset_n=0 during VECTOR → all outputs 0 immediately, FSM=IDLE.
- With IRQ_FLAG_SAVE_EN: z=1, carry=0 at entry → z_sh=1, carry_sh=0, and flag_restore=1 in RESTORE.
